// File: rtl/fma_seq_pkg.sv
// Shared definitions for the FMA dot-product sequencer: register map,
// STATUS/CTRL bit positions and the sequencer state encoding.
package fma_seq_pkg;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h04;
    localparam logic [4:0] REG_LEN    = 5'h08;
    localparam logic [4:0] REG_RESULT = 5'h0C;
    localparam logic [4:0] REG_A_PUSH = 5'h10;
    localparam logic [4:0] REG_B_PUSH = 5'h14;
    localparam int         REG_SPAN   = 'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERR      = 2;
    localparam int STAT_OVF      = 3;
    localparam int STAT_ACNT_LSB = 8;
    localparam int STAT_BCNT_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } seq_state_e;

endpackage

// File: rtl/operand_buffer.sv
// Append-only operand store: pushes land at the current count, reads are
// random-access by element index.
module operand_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       clear_i,
    input  logic [XLEN-1:0]            data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [XLEN-1:0]            rd_data_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [CW-1:0]   cnt_q;

    assign cnt_o     = cnt_q;
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign rd_data_o = mem[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; cnt_q alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem[cnt_q[IW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fma_dot_sequencer.sv
// Bus-mapped controller that drives an external FMA core one element at a
// time to accumulate the dot product of the A and B operand buffers.
module fma_dot_sequencer
    import fma_seq_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] BASE  = 32'hC4300000,
    parameter int              DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic            ready_o,
    output logic [XLEN-1:0] data_o,
    output logic            fma_a_tvalid_o,
    output logic            fma_b_tvalid_o,
    output logic            fma_c_tvalid_o,
    output logic [XLEN-1:0] fma_a_tdata_o,
    output logic [XLEN-1:0] fma_b_tdata_o,
    output logic [XLEN-1:0] fma_c_tdata_o,
    input  logic            fma_res_tvalid_i,
    input  logic [XLEN-1:0] fma_res_tdata_i
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    seq_state_e      state_q;
    logic [IW-1:0]   idx_q, rd_idx;
    logic [XLEN-1:0] acc_q, result_q, rdata, status;
    logic [7:0]      len_q;
    logic            done_q, err_q, ovf_q, op_valid_q, busy;
    logic            in_win, wr, ctrl_wr, start_req, clear_req, a_push_req, b_push_req;
    logic [4:0]      off;
    logic [XLEN-1:0] a_rd, b_rd;
    logic [CW-1:0]   a_cnt, b_cnt;
    logic            a_full, b_full;

    // Offset arithmetic only needs the low bits once the window check passes.
    assign in_win     = en_i && (addr_i >= BASE) && ((addr_i - BASE) <= XLEN'(REG_SPAN));
    assign off        = addr_i[4:0] - BASE[4:0];
    assign wr         = in_win && we_i;
    assign busy       = (state_q != S_IDLE);
    assign ctrl_wr    = wr && (off == REG_CTRL);
    assign start_req  = ctrl_wr && data_i[CTRL_START];
    assign clear_req  = ctrl_wr && data_i[CTRL_CLEAR] && !busy;
    assign a_push_req = wr && (off == REG_A_PUSH);
    assign b_push_req = wr && (off == REG_B_PUSH);

    // The next element is fetched while waiting so it is ready when the result lands.
    assign rd_idx = (state_q == S_WAIT) ? idx_q + 1'b1 : '0;

    assign fma_a_tvalid_o = op_valid_q;
    assign fma_b_tvalid_o = op_valid_q;
    assign fma_c_tvalid_o = op_valid_q;

    operand_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) u_buf_a (
        .clk_i, .rst_ni,
        .push_i   (a_push_req && !busy),
        .clear_i  (clear_req),
        .data_i,
        .rd_idx_i (rd_idx),
        .rd_data_o(a_rd),
        .cnt_o    (a_cnt),
        .full_o   (a_full)
    );

    operand_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) u_buf_b (
        .clk_i, .rst_ni,
        .push_i   (b_push_req && !busy),
        .clear_i  (clear_req),
        .data_i,
        .rd_idx_i (rd_idx),
        .rd_data_o(b_rd),
        .cnt_o    (b_cnt),
        .full_o   (b_full)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = busy;
        status[STAT_DONE]                 = done_q;
        status[STAT_ERR]                  = err_q;
        status[STAT_OVF]                  = ovf_q;
        status[STAT_ACNT_LSB +: 8]        = 8'(a_cnt);
        status[STAT_BCNT_LSB +: 8]        = 8'(b_cnt);
        rdata = '0;
        case (off)
            REG_STATUS: rdata = status;
            REG_LEN:    rdata = XLEN'(len_q);
            REG_RESULT: rdata = result_q;
            default:    rdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ready_o <= 1'b0;
            data_o  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ready_o <= in_win;
            data_o  <= (in_win && !we_i) ? rdata : '0;
            if (wr && (off == REG_LEN) && !busy) begin
                len_q <= data_i[7:0];
            end
            if (clear_req) begin
                ovf_q <= 1'b0;
            end else if ((a_push_req && (busy || a_full)) || (b_push_req && (busy || b_full))) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            op_valid_q    <= 1'b0;
            fma_a_tdata_o <= '0;
            fma_b_tdata_o <= '0;
            fma_c_tdata_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // CLEAR wins if both command bits arrive in one write.
                    if (clear_req) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end else if (start_req) begin
                        if (len_q > 8'(a_cnt) || len_q > 8'(b_cnt)) begin
                            err_q <= 1'b1;
                        end else if (len_q == 8'd0) begin
                            result_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            state_q       <= S_ISSUE;
                            idx_q         <= '0;
                            acc_q         <= '0;
                            done_q        <= 1'b0;
                            err_q         <= 1'b0;
                            op_valid_q    <= 1'b1;
                            fma_a_tdata_o <= a_rd;
                            fma_b_tdata_o <= b_rd;
                            fma_c_tdata_o <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    op_valid_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (fma_res_tvalid_i) begin
                        acc_q <= fma_res_tdata_i;
                        if (8'(idx_q) == len_q - 8'd1) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q         <= idx_q + 1'b1;
                            state_q       <= S_ISSUE;
                            op_valid_q    <= 1'b1;
                            fma_a_tdata_o <= a_rd;
                            fma_b_tdata_o <= b_rd;
                            fma_c_tdata_o <= fma_res_tdata_i;
                        end
                    end
                end
                S_FIN: begin
                    result_q <= acc_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Bench for fma_dot_sequencer: register table, directed corner runs and
// randomized dot products against an integer-valued float reference.
module tb_fma_dot_sequencer;

    localparam logic [31:0] BASE  = 32'hC4300000;
    localparam int          DEPTH = 16;
    localparam logic [31:0] O_CTRL = 32'h00, O_STATUS = 32'h04, O_LEN = 32'h08;
    localparam logic [31:0] O_RESULT = 32'h0C, O_APUSH = 32'h10, O_BPUSH = 32'h14;

    logic        clk_i = 1'b0;
    logic        rst_ni, en_i, we_i;
    logic [31:0] addr_i, data_i, data_o;
    logic        ready_o;
    logic        fma_a_tvalid_o, fma_b_tvalid_o, fma_c_tvalid_o;
    logic [31:0] fma_a_tdata_o, fma_b_tdata_o, fma_c_tdata_o;
    logic        fma_res_tvalid_i;
    logic [31:0] fma_res_tdata_i;

    int total = 0;
    int bad   = 0;

    // FMA model state and a log of every issued operand triple
    int          lat = 5;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_val;
    int          delivered = 0;
    logic [31:0] log_a[$], log_b[$], log_c[$];

    always #5 clk_i = ~clk_i;

    fma_dot_sequencer #(.XLEN(32), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .ready_o(ready_o), .data_o(data_o),
        .fma_a_tvalid_o(fma_a_tvalid_o), .fma_b_tvalid_o(fma_b_tvalid_o),
        .fma_c_tvalid_o(fma_c_tvalid_o), .fma_a_tdata_o(fma_a_tdata_o),
        .fma_b_tdata_o(fma_b_tdata_o), .fma_c_tdata_o(fma_c_tdata_o),
        .fma_res_tvalid_i(fma_res_tvalid_i), .fma_res_tdata_i(fma_res_tdata_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact conversions for integer-valued single-precision numbers
    function automatic logic [31:0] int_to_sp(input int v);
        logic [31:0] mag;
        int          e;
        logic        s;
        if (v == 0) return 32'h0;
        s   = (v < 0);
        mag = s ? -v : v;
        e   = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) e = i;
        return {s, 8'(127 + e), 23'(mag << (23 - e))};
    endfunction

    function automatic int sp_to_int(input logic [31:0] f);
        int e;
        int mag;
        if (f[30:0] == 31'h0) return 0;
        e   = int'(f[30:23]) - 127;
        mag = int'({1'b1, f[22:0]} >> (23 - e));
        return f[31] ? -mag : mag;
    endfunction

    // FMA core model: one result per issue, lat cycles later
    initial begin
        fma_res_tvalid_i = 1'b0;
        fma_res_tdata_i  = '0;
        pend             = 1'b0;
        pend_cnt         = 0;
        pend_val         = '0;
        forever begin
            @(negedge clk_i);
            fma_res_tvalid_i = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    fma_res_tvalid_i = 1'b1;
                    fma_res_tdata_i  = pend_val;
                    pend             = 1'b0;
                    delivered++;
                end
            end
            if (fma_a_tvalid_o || fma_b_tvalid_o || fma_c_tvalid_o) begin
                check("tvalid_together", {29'd0, fma_a_tvalid_o, fma_b_tvalid_o, fma_c_tvalid_o}, 32'd7);
                check("one_outstanding", {31'd0, pend}, 32'd0);
                log_a.push_back(fma_a_tdata_o);
                log_b.push_back(fma_b_tdata_o);
                log_c.push_back(fma_c_tdata_o);
                pend     = 1'b1;
                pend_cnt = lat;
                pend_val = int_to_sp(sp_to_int(fma_a_tdata_o) * sp_to_int(fma_b_tdata_o)
                                     + sp_to_int(fma_c_tdata_o));
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic rdy);
        @(posedge clk_i); #1;
        en_i = 1'b1; we_i = we; addr_i = addr; data_i = wdata;
        @(posedge clk_i); #1;
        en_i = 1'b0; we_i = 1'b0;
        rdy   = ready_o;
        rdata = data_o;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r;
        logic        k;
        bus(1'b1, BASE + off, d, r, k);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        logic k;
        bus(1'b0, BASE + off, 32'h0, d, k);
    endtask

    task automatic wait_idle(output logic ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rd(O_STATUS, s);
            if (!s[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        log_a.delete(); log_b.delete(); log_c.delete();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs[$];
        logic [31:0] r, s;
        logic        k, ok;
        int          av[DEPTH], bv[DEPTH];
        int          n, sum;

        rst_ni = 1'b0; en_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_tvalid", {29'd0, fma_a_tvalid_o, fma_b_tvalid_o, fma_c_tvalid_o}, 32'd0);
        check("rst_tdata", fma_a_tdata_o | fma_b_tdata_o | fma_c_tdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Register-level table
        vecs.push_back('{1'b1, BASE + O_LEN,    32'd5,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_STATUS, 32'd0,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_LEN,    32'd0,      1'b1, 32'd5});
        vecs.push_back('{1'b0, BASE + O_CTRL,   32'd0,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_APUSH,  32'd0,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + 32'h02,   32'd0,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + 32'h18,   32'd0,      1'b0, 32'h0});
        vecs.push_back('{1'b0, BASE - 32'h4,    32'd0,      1'b0, 32'h0});
        vecs.push_back('{1'b1, BASE + O_APUSH,  32'd1,      1'b1, 32'h0});
        vecs.push_back('{1'b1, BASE + O_APUSH,  32'd2,      1'b1, 32'h0});
        vecs.push_back('{1'b1, BASE + O_BPUSH,  32'd3,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_STATUS, 32'd0,      1'b1, 32'h00010200});
        vecs.push_back('{1'b1, BASE + O_LEN,    32'h1FF,    1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_LEN,    32'd0,      1'b1, 32'hFF});
        vecs.push_back('{1'b0, BASE + O_RESULT, 32'd0,      1'b1, 32'h0});
        vecs.push_back('{1'b1, BASE + O_CTRL,   32'd2,      1'b1, 32'h0});
        vecs.push_back('{1'b0, BASE + O_STATUS, 32'd0,      1'b1, 32'h0});
        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, r, k);
            check($sformatf("vec%0d_ready", i), {31'd0, k}, {31'd0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_data", i), r, vecs[i].exp_rdata);
        end

        // Two-element run: 1*3 + 2*4 = 11
        lat = 5;
        clear_log();
        wr(O_APUSH, 32'h3F800000); wr(O_APUSH, 32'h40000000);
        wr(O_BPUSH, 32'h40400000); wr(O_BPUSH, 32'h40800000);
        wr(O_LEN, 32'd2);
        wr(O_CTRL, 32'd1);
        wait_idle(ok);
        check("run2_finished", {31'd0, ok}, 32'd1);
        check("run2_issues", log_a.size(), 32'd2);
        if (log_a.size() == 2) begin
            check("run2_a0", log_a[0], 32'h3F800000);
            check("run2_b0", log_b[0], 32'h40400000);
            check("run2_c0", log_c[0], 32'h0);
            check("run2_a1", log_a[1], 32'h40000000);
            check("run2_c1", log_c[1], 32'h40400000);
        end
        rd(O_STATUS, s);
        check("run2_status", s, 32'h00020202);
        rd(O_RESULT, r);
        check("run2_result", r, 32'h41300000);
        rd(O_STATUS, s);
        check("run2_done_sticky", {31'd0, s[1]}, 32'd1);

        // LEN larger than pushed data
        clear_log();
        wr(O_LEN, 32'd3);
        wr(O_CTRL, 32'd1);
        rd(O_STATUS, s);
        check("err_status", s & 32'h7, 32'h5 & 32'h4 | 32'h2);
        repeat (5) @(posedge clk_i);
        check("err_no_issue", log_a.size(), 32'd0);

        // Zero-length run
        wr(O_LEN, 32'd0);
        wr(O_CTRL, 32'd1);
        rd(O_STATUS, s);
        check("len0_done", s & 32'h3, 32'h2);
        rd(O_RESULT, r);
        check("len0_result", r, 32'h0);
        check("len0_no_issue", log_a.size(), 32'd0);

        // Overflow of A buffer, then CLEAR
        wr(O_CTRL, 32'd2);
        for (int i = 0; i < DEPTH + 1; i++) wr(O_APUSH, 32'(i));
        rd(O_STATUS, s);
        check("ovf_status", s, 32'h00001008);
        wr(O_CTRL, 32'd2);
        rd(O_STATUS, s);
        check("clear_status", s, 32'h0);

        // Randomized runs against a plain-arithmetic dot product
        for (int t = 0; t < 6; t++) begin
            wr(O_CTRL, 32'd2);
            n   = $urandom_range(1, DEPTH);
            lat = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                av[i] = int'($urandom_range(0, 16)) - 8;
                bv[i] = int'($urandom_range(0, 16)) - 8;
                wr(O_APUSH, int_to_sp(av[i]));
                wr(O_BPUSH, int_to_sp(bv[i]));
            end
            wr(O_LEN, 32'(n));
            clear_log();
            wr(O_CTRL, 32'd1);
            wait_idle(ok);
            check($sformatf("rand%0d_finished", t), {31'd0, ok}, 32'd1);
            check($sformatf("rand%0d_issues", t), log_a.size(), 32'(n));
            sum = 0;
            for (int i = 0; i < n; i++) begin
                if (i < log_a.size()) begin
                    check($sformatf("rand%0d_a%0d", t, i), log_a[i], int_to_sp(av[i]));
                    check($sformatf("rand%0d_b%0d", t, i), log_b[i], int_to_sp(bv[i]));
                    check($sformatf("rand%0d_c%0d", t, i), log_c[i], int_to_sp(sum));
                end
                sum += av[i] * bv[i];
            end
            rd(O_RESULT, r);
            check($sformatf("rand%0d_result", t), r, int_to_sp(sum));
            rd(O_STATUS, s);
            check($sformatf("rand%0d_status", t), s, (32'(n) << 16) | (32'(n) << 8) | 32'h2);
        end

        // Four-element run disturbed while waiting on the FMA
        wr(O_CTRL, 32'd2);
        for (int i = 1; i <= 4; i++) begin
            wr(O_APUSH, int_to_sp(i));
            wr(O_BPUSH, int_to_sp(i));
        end
        wr(O_LEN, 32'd4);
        lat = 25;
        clear_log();
        wr(O_CTRL, 32'd1);
        for (int i = 0; i < 50 && log_a.size() == 0; i++) @(posedge clk_i);
        check("wait_first_issue", log_a.size(), 32'd1);
        wr(O_CTRL, 32'd1);
        wr(O_APUSH, 32'h3F800000);
        rd(O_STATUS, s);
        check("wait_status", s, 32'h00040409);
        check("wait_start_ignored", log_a.size(), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_data", data_o, 32'd0);
        check("midrst_tvalid", {29'd0, fma_a_tvalid_o, fma_b_tvalid_o, fma_c_tvalid_o}, 32'd0);
        check("midrst_tdata", fma_a_tdata_o | fma_b_tdata_o | fma_c_tdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        n = delivered;
        repeat (40) @(posedge clk_i);
        check("stale_result_arrived", delivered, n + 1);
        check("stale_no_issue", log_a.size(), 32'd1);
        rd(O_RESULT, r);
        check("stale_result", r, 32'h0);
        rd(O_STATUS, s);
        check("stale_status", s, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
- Memory-mapped controller that sequences one external single-precision FMA core (a*b+c, AXI-stream-style operand/result valids) to compute a dot product of two buffered vectors.
- CPU pushes A and B elements over the device bus, writes LEN, then writes START.
- Block issues one FMA per element, feeding each result back as the accumulator. CPU polls STATUS and reads RESULT.
- Sits on the device bus beside the FMA instance; the FMA itself lives outside this block.

Parameters:
- XLEN, 32, bus and float data width
- BASE, 32'hC4300000, bus window base address
- DEPTH, 16, entries per operand buffer (power of two)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- en_i  in  1  bus access strobe
- we_i  in  1  1=write, 0=read
- addr_i  in  XLEN  byte address
- data_i  in  XLEN  write data
- ready_o  out  1  access acknowledge
- data_o  out  XLEN  read data
- fma_a_tvalid_o / fma_b_tvalid_o / fma_c_tvalid_o  out  1  operand valids, always driven together
- fma_a_tdata_o / fma_b_tdata_o / fma_c_tdata_o  out  XLEN  operands a, b, c (c = accumulator)
- fma_res_tvalid_i  in  1  FMA result valid
- fma_res_tdata_i  in  XLEN  FMA result

Behaviour:
- Reset (clk_i edge with rst_ni=0):
  - ready_o=0, data_o=0, all fma_*_tvalid_o=0, operand data outputs 0.
  - FSM=IDLE, pointers/counts=0, acc=0, RESULT=0, LEN=0, flags clear.
- Register map (offsets from BASE):
  - 0x00 CTRL, write-only: bit0 START, bit1 CLEAR.
  - 0x04 STATUS, read: bit0 busy, bit1 done, bit2 err, bit3 ovf, [15:8] a_cnt, [23:16] b_cnt.
  - 0x08 LEN, read/write, [7:0].
  - 0x0C RESULT, read-only.
  - 0x10 A_PUSH, write-only.
  - 0x14 B_PUSH, write-only.
- Bus timing:
  - Any en_i access with addr_i inside [BASE, BASE+0x14] gets ready_o=1 exactly one cycle later, for one cycle.
  - data_o is valid in that same cycle. Reads of write-only or unmapped in-window offsets return 0.
  - Accesses outside the window get no ready_o. ready_o=0 whenever no access completes.
- Push:
  - A_PUSH writes A[a_cnt] and increments a_cnt. B_PUSH does the same for B/b_cnt.
  - If a count is already DEPTH, the push is dropped and ovf is set.
  - Pushes while busy are dropped and set ovf.
- CLEAR: a_cnt=b_cnt=0; done, err, ovf cleared. Ignored while busy.
- START: ignored while busy.
  - If LEN>a_cnt or LEN>b_cnt: err=1, no run.
  - If LEN==0: RESULT=32'h0, done=1, no FMA issue.
  - Otherwise: idx=0, acc=32'h0, done=0, err=0, enter ISSUE.
- FSM (IDLE, ISSUE, WAIT, FIN):
  - ISSUE, 1 cycle: all three tvalids=1 with a=A[idx], b=B[idx], c=acc → WAIT.
  - WAIT: tvalids=0. On fma_res_tvalid_i: acc<=fma_res_tdata_i. If idx==LEN-1 → FIN, else idx++ → ISSUE.
  - FIN, 1 cycle: RESULT<=acc, done=1 → IDLE.
  - busy=1 in ISSUE/WAIT/FIN.
  - Exactly one FMA operation is outstanding at a time.
- fma_res_tvalid_i outside WAIT is ignored (stale results after reset or CLEAR).
- A read of RESULT does not clear done. Only START or CLEAR clears it.
- Bus write and FSM activity in the same cycle are independent.
- LEN writes while busy are ignored, so the running length is stable.
- rst_ni low mid-run aborts immediately to reset state. Any later FMA result is ignored.

Decomposition:
- Shared package fma_seq_pkg holds:
  - register offset localparams (CTRL, STATUS, LEN, RESULT, A_PUSH, B_PUSH);
  - the FSM state encoding;
  - STATUS bit-index constants.
- One natural sub-module: operand_buffer, a DEPTH x XLEN write-pointer array with a count and a random read port, instantiated twice (A and B).

Test Plan:
- Reset, then read STATUS → ready_o one cycle later, data_o=0. tvalids=0 throughout.
- Push A={3F800000, 40000000}, B={40400000, 40800000}, LEN=2, START, with an FMA model of 5-cycle latency → two single-cycle issue pulses, c=0 then c=40400000. Then done=1 and RESULT=41300000 (11.0).
- LEN=3 with only 2 elements pushed, START → err=1, busy stays 0, no tvalid pulse.
- LEN=0, START → done=1 and RESULT=0 within 2 cycles, no FMA issue.
- Push 17 elements to A with DEPTH=16 → a_cnt=16, ovf=1. CLEAR → a_cnt=0, ovf=0.
- During WAIT of a 4-element run:
  - write START and A_PUSH → both ignored, ovf=1.
  - deassert rst_ni for one cycle → all outputs at reset values.
  - delayed fma_res_tvalid_i arrives → ignored, RESULT stays 0.
